// File: rtl/dircc_mem_arb_pkg.sv
// rtl/dircc_mem_arb_pkg.sv - shared types and constants for the port-B arbiter
package dircc_mem_arb_pkg;

    typedef logic master_id_t;

    localparam int PB_ADDR_W  = 14;
    localparam int PB_DATA_W  = 16;
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/dircc_rr_lock_arbiter_2.sv
// rtl/dircc_rr_lock_arbiter_2.sv - two-way round-robin grant with bounded lock
module dircc_rr_lock_arbiter_2
    import dircc_mem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_freeze,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    output master_id_t o_grant,
    output logic       o_accept
);

    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    master_id_t       r_last_grant;
    logic [CNT_W-1:0] r_lock_cnt;

    master_id_t       w_grant;
    logic             w_owner_locked;
    logic [CNT_W-1:0] w_cnt_base;

    // A lock only counts while its owner keeps requesting.
    assign w_owner_locked = (r_lock_cnt != '0) & i_req[r_last_grant];

    always_comb begin
        w_grant = r_last_grant;
        if (!w_owner_locked) begin
            if (&i_req)
                w_grant = ~r_last_grant;
            else if (i_req[0])
                w_grant = 1'b0;
            else if (i_req[1])
                w_grant = 1'b1;
        end
    end

    assign o_grant    = w_grant;
    assign o_accept   = |i_req & ~i_freeze;
    assign w_cnt_base = (w_grant == r_last_grant) ? r_lock_cnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else if (!i_freeze) begin
            if (o_accept) begin
                r_last_grant <= w_grant;
                if (i_lock[w_grant] && (w_cnt_base < CNT_LAST))
                    r_lock_cnt <= w_cnt_base + CNT_W'(1);
                else
                    r_lock_cnt <= '0;
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dircc_processing_mem_port_b_arbiter.sv
// rtl/dircc_processing_mem_port_b_arbiter.sv - shares RAM port B between RX writer and TX reader
module dircc_processing_mem_port_b_arbiter
    import dircc_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = PB_ADDR_W,
    parameter int DATA_W   = PB_DATA_W,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address2,
    output logic                mem_chipselect2,
    output logic                mem_write2,
    output logic [DATA_W-1:0]   mem_writedata2,
    output logic [DATA_W/8-1:0] mem_byteenable2,
    output logic                mem_clken2,
    input  logic [DATA_W-1:0]   mem_readdata2
);

    logic [1:0] w_req;
    master_id_t w_grant;
    logic       w_accept;
    logic       w_sel_read;
    logic       w_sel_write;

    logic [RD_LATENCY-1:0] r_rd_pend;
    master_id_t            r_rd_id [RD_LATENCY];

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    dircc_rr_lock_arbiter_2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_freeze (freeze),
        .i_req    (w_req),
        .i_lock   ({m1_lock, m0_lock}),
        .o_grant  (w_grant),
        .o_accept (w_accept)
    );

    assign m0_waitrequest = w_req[0] & ~(w_accept & (w_grant == 1'b0));
    assign m1_waitrequest = w_req[1] & ~(w_accept & (w_grant == 1'b1));

    // With no requester the grant rests on the last owner, so the mux holds its values.
    assign w_sel_read      = w_grant ? m1_read       : m0_read;
    assign w_sel_write     = w_grant ? m1_write      : m0_write;
    assign mem_address2    = w_grant ? m1_address    : m0_address;
    assign mem_writedata2  = w_grant ? m1_writedata  : m0_writedata;
    assign mem_byteenable2 = w_grant ? m1_byteenable : m0_byteenable;
    assign mem_chipselect2 = w_accept;
    assign mem_write2      = w_accept & w_sel_write;
    assign mem_clken2      = ~freeze;

    // Write wins over a simultaneous read, so such a beat never returns data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= '0;
            for (int k = 0; k < RD_LATENCY; k++)
                r_rd_id[k] <= 1'b0;
        end else begin
            r_rd_pend[0] <= w_accept & w_sel_read & ~w_sel_write;
            r_rd_id[0]   <= w_grant;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_rd_pend[k] <= r_rd_pend[k-1];
                r_rd_id[k]   <= r_rd_id[k-1];
            end
        end
    end

    assign m0_readdatavalid = r_rd_pend[RD_LATENCY-1] & (r_rd_id[RD_LATENCY-1] == 1'b0);
    assign m1_readdatavalid = r_rd_pend[RD_LATENCY-1] & (r_rd_id[RD_LATENCY-1] == 1'b1);
    assign m0_readdata      = mem_readdata2;
    assign m1_readdata      = mem_readdata2;

endmodule

// File: tb/tb_dircc_processing_mem_port_b_arbiter.sv
// tb/tb_dircc_processing_mem_port_b_arbiter.sv - self-checking bench for the port-B arbiter
module tb_dircc_processing_mem_port_b_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0, reset_n = 1'b0, freeze = 1'b0;
    logic        m0_read = 0, m0_write = 0, m0_lock = 0;
    logic [13:0] m0_address = '0;
    logic [15:0] m0_writedata = '0;
    logic [1:0]  m0_byteenable = 2'b11;
    logic        m0_waitrequest, m0_readdatavalid;
    logic [15:0] m0_readdata;
    logic        m1_read = 0, m1_write = 0, m1_lock = 0;
    logic [13:0] m1_address = '0;
    logic [15:0] m1_writedata = '0;
    logic [1:0]  m1_byteenable = 2'b11;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [15:0] m1_readdata;
    logic [13:0] mem_address2;
    logic        mem_chipselect2, mem_write2, mem_clken2;
    logic [15:0] mem_writedata2;
    logic [1:0]  mem_byteenable2;
    logic [15:0] mem_readdata2 = '0;

    dircc_processing_mem_port_b_arbiter #(.ADDR_W(14), .DATA_W(16), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address2(mem_address2), .mem_chipselect2(mem_chipselect2), .mem_write2(mem_write2),
        .mem_writedata2(mem_writedata2), .mem_byteenable2(mem_byteenable2), .mem_clken2(mem_clken2),
        .mem_readdata2(mem_readdata2)
    );

    always #5 clk = ~clk;

    // RAM behind port B, one cycle read latency
    logic [15:0] ram    [16384];
    logic [15:0] shadow [16384];
    always @(posedge clk) begin
        if (mem_clken2 && mem_chipselect2) begin
            if (mem_write2) begin
                if (mem_byteenable2[0]) ram[mem_address2][7:0]  <= mem_writedata2[7:0];
                if (mem_byteenable2[1]) ram[mem_address2][15:8] <= mem_writedata2[15:8];
            end else begin
                mem_readdata2 <= ram[mem_address2];
            end
        end
    end

    int n_illegal = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (m0_read && m0_write) begin n_illegal++; $display("note: m0 read and write asserted together"); end
            if (m1_read && m1_write) begin n_illegal++; $display("note: m1 read and write asserted together"); end
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: owner of the last beat plus the length of its current locked run
    int          m_owner, m_streak, m_pid;
    bit          m_pend;
    logic [15:0] m_pdata;

    task automatic model_reset();
        m_owner = 1; m_streak = 0; m_pend = 0; m_pid = 0;
    endtask

    typedef struct {
        logic rd0, wr0; logic [13:0] a0; logic [15:0] d0;
        logic rd1, wr1; logic [13:0] a1;
        logic cs, we, wt0, wt1, rv0, rv1; logic [13:0] addr; logic [15:0] rdata;
    } vec_t;
    vec_t vt[7];

    int          obs_g;
    logic        obs_cs, obs_we, obs_rv0, obs_rv1;
    logic [15:0] obs_rd0;

    task automatic cycle(int vi);
        bit rq[2], wr[2], lk[2], pri, acc;
        logic [13:0] a[2]; logic [15:0] d[2]; logic [1:0] be[2];
        int g;
        @(negedge clk);
        rq[0] = m0_read | m0_write; rq[1] = m1_read | m1_write;
        wr[0] = m0_write; wr[1] = m1_write; lk[0] = m0_lock; lk[1] = m1_lock;
        a[0] = m0_address; a[1] = m1_address; d[0] = m0_writedata; d[1] = m1_writedata;
        be[0] = m0_byteenable; be[1] = m1_byteenable;
        obs_cs = mem_chipselect2; obs_we = mem_write2; obs_rv0 = m0_readdatavalid;
        obs_rv1 = m1_readdatavalid; obs_rd0 = m0_readdata;
        obs_g = !mem_chipselect2 ? -1 : (!m0_waitrequest && rq[0]) ? 0 : 1;

        pri = (m_streak > 0) && (m_streak < MAX_LOCK) && rq[m_owner];
        if (!rq[0] && !rq[1]) g = -1;
        else if (pri) g = m_owner;
        else if (rq[0] && rq[1]) g = 1 - m_owner;
        else g = rq[0] ? 0 : 1;
        acc = (g >= 0) && !freeze;

        chk("wait0", m0_waitrequest, rq[0] && !(acc && g == 0));
        chk("wait1", m1_waitrequest, rq[1] && !(acc && g == 1));
        chk("cs", mem_chipselect2, acc);
        chk("we", mem_write2, acc && wr[g]);
        chk("clken", mem_clken2, !freeze);
        chk("rv0", m0_readdatavalid, m_pend && m_pid == 0);
        chk("rv1", m1_readdatavalid, m_pend && m_pid == 1);
        if (m_pend) chk("rdata", m_pid == 0 ? m0_readdata : m1_readdata, m_pdata);
        if (acc) chk("addr", mem_address2, a[g]);
        if (acc && wr[g]) begin
            chk("wdata", mem_writedata2, d[g]);
            chk("be", mem_byteenable2, be[g]);
        end

        if (vi >= 0) begin
            chk($sformatf("tbl%0d_cs", vi), mem_chipselect2, vt[vi].cs);
            chk($sformatf("tbl%0d_we", vi), mem_write2, vt[vi].we);
            chk($sformatf("tbl%0d_wt0", vi), m0_waitrequest, vt[vi].wt0);
            chk($sformatf("tbl%0d_wt1", vi), m1_waitrequest, vt[vi].wt1);
            chk($sformatf("tbl%0d_rv0", vi), m0_readdatavalid, vt[vi].rv0);
            chk($sformatf("tbl%0d_rv1", vi), m1_readdatavalid, vt[vi].rv1);
            if (vt[vi].cs) chk($sformatf("tbl%0d_addr", vi), mem_address2, vt[vi].addr);
            if (vt[vi].rv0) chk($sformatf("tbl%0d_rd0", vi), m0_readdata, vt[vi].rdata);
            if (vt[vi].rv1) chk($sformatf("tbl%0d_rd1", vi), m1_readdata, vt[vi].rdata);
        end

        if (freeze) begin
            m_pend = 0;
        end else if (acc) begin
            if (wr[g]) begin
                if (be[g][0]) shadow[a[g]][7:0]  = d[g][7:0];
                if (be[g][1]) shadow[a[g]][15:8] = d[g][15:8];
                m_pend = 0;
            end else begin
                m_pend = 1; m_pid = g; m_pdata = shadow[a[g]];
            end
            if (g != m_owner) m_streak = 0;
            m_owner = g;
            m_streak = lk[g] ? m_streak + 1 : 0;
            if (m_streak == MAX_LOCK) m_streak = 0;
        end else begin
            m_pend = 0; m_streak = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_lock = 0; m1_read = 0; m1_write = 0; m1_lock = 0;
        m0_byteenable = 2'b11; m1_byteenable = 2'b11; freeze = 0;
    endtask

    task automatic do_reset();
        reset_n = 0; idle_inputs(); model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
    endtask

    int lock_exp[13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    int n1;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i] = 16'(i) ^ 16'hA5A5; shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        vt[0] = '{0,1,14'h10,16'hBEEF, 0,0,14'h0,  1,1,0,0,0,0,14'h10,16'h0};
        vt[1] = '{1,0,14'h10,16'h0,    0,0,14'h0,  1,0,0,0,0,0,14'h10,16'h0};
        vt[2] = '{0,0,14'h0, 16'h0,    0,0,14'h0,  0,0,0,0,1,0,14'h0, 16'hBEEF};
        vt[3] = '{1,0,14'h20,16'h0,    1,0,14'h30, 1,0,1,0,0,0,14'h30,16'h0};
        vt[4] = '{1,0,14'h20,16'h0,    1,0,14'h30, 1,0,0,1,0,1,14'h20,16'hA595};
        vt[5] = '{1,0,14'h20,16'h0,    1,0,14'h30, 1,0,1,0,1,0,14'h30,16'hA585};
        vt[6] = '{0,0,14'h0, 16'h0,    0,0,14'h0,  0,0,0,0,0,1,14'h0, 16'hA595};

        #3;
        chk("reset_rv0", m0_readdatavalid, 0);
        chk("reset_rv1", m1_readdatavalid, 0);
        chk("reset_cs", mem_chipselect2, 0);
        chk("reset_we", mem_write2, 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            m0_read = vt[i].rd0; m0_write = vt[i].wr0; m0_address = vt[i].a0; m0_writedata = vt[i].d0;
            m1_read = vt[i].rd1; m1_write = vt[i].wr1; m1_address = vt[i].a1;
            cycle(i);
        end

        // lock bound: m1 locked writes against a continuously requesting m0
        do_reset();
        m0_write = 1; m0_address = 14'h100; m0_writedata = 16'h0001;
        m1_lock = 1; m1_address = 14'h200; m1_writedata = 16'h0002;
        n1 = 0;
        for (int i = 0; i < 13; i++) begin
            m1_write = (n1 < 10);
            cycle(-1);
            chk($sformatf("lock_seq%0d", i), obs_g, lock_exp[i]);
            if (obs_g == 1) n1++;
        end
        chk("lock_m1_beats", n1, 10);

        // freeze after a read accept
        do_reset();
        m0_read = 1; m0_address = 14'h40;
        cycle(-1);
        chk("frz_pre_acc", obs_g, 0);
        freeze = 1; m0_address = 14'h41; m1_read = 1; m1_address = 14'h50;
        cycle(-1);
        chk("frz_rv0", obs_rv0, 1);
        chk("frz_rd0", obs_rd0, 16'hA5E5);
        chk("frz_cs", obs_cs, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(-1);
            chk("frz_hold_cs", obs_cs, 0);
            chk("frz_hold_rv0", obs_rv0, 0);
        end
        freeze = 0;
        cycle(-1);
        chk("frz_resume_ptr", obs_g, 1);
        idle_inputs();

        // async reset with a read in flight
        m0_read = 1; m0_address = 14'h44;
        cycle(-1);
        #2 reset_n = 0; idle_inputs(); model_reset();
        #1;
        chk("arst_rv0", m0_readdatavalid, 0);
        chk("arst_cs", mem_chipselect2, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        cycle(-1);
        chk("arst_no_rv0", obs_rv0, 0);
        chk("arst_no_rv1", obs_rv1, 0);
        m0_read = 1; m0_address = 14'h60; m1_read = 1; m1_address = 14'h61;
        cycle(-1);
        chk("arst_first_contention", obs_g, 0);
        idle_inputs();
        cycle(-1);

        // illegal read+write: write wins
        m0_read = 1; m0_write = 1; m0_address = 14'h5; m0_writedata = 16'h1234;
        cycle(-1);
        chk("ill_we", obs_we, 1);
        idle_inputs();
        cycle(-1);
        chk("ill_no_rv0", obs_rv0, 0);
        chk("ill_ram", ram[5], 16'h1234);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op0, op1;
            op0 = $urandom_range(0, 3); op1 = $urandom_range(0, 3);
            m0_read = (op0 == 1 || op0 == 3); m0_write = (op0 == 2);
            m1_read = (op1 == 1 || op1 == 3); m1_write = (op1 == 2);
            m0_address = 14'($urandom_range(0, 63)); m1_address = 14'($urandom_range(0, 63));
            m0_writedata = 16'($urandom); m1_writedata = 16'($urandom);
            m0_byteenable = 2'($urandom); m1_byteenable = 2'($urandom);
            m0_lock = 1'($urandom); m1_lock = 1'($urandom);
            freeze = ($urandom_range(0, 9) == 0);
            cycle(-1);
        end
        idle_inputs();
        cycle(-1);
        chk("illegal_flagged", n_illegal, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
